alu_decode_stage: RTL and testbench

- Registered decode stage that sits in front of alu_core and produces the operation encoding that alu_core consumes.
- Accepts 32-bit RV32 OP and OP-IMM instructions over a valid/ready handshake.
- Emits alu_sel, register indices, immediate, operand-select and an illegal flag from a 2-entry skid-buffered output register.
- Sustains 1 instruction/cycle with 1-cycle latency and is fully backpressurable.

---
 rtl/alu_decode_stage.sv | 278 +++++++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32 OP / OP-IMM decoder feeding alu_core.
// Holds up to two decoded entries (main + skid) so that in_ready can be a
// registered signal while still sustaining one instruction per cycle.
// Optional Zbb decoding is enabled by defining ALU_DECODE_ZBB_EN; without it
// every Zbb encoding decodes as illegal.

module alu_decode_stage #(
    parameter int unsigned SKID_EN_DEPTH = 2,
    parameter logic [4:0]  NOP_SEL       = 5'h0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_alu_sel,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_use_imm,
    output logic [31:0] out_imm,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [4:0] SEL_AND  = 5'h00;
    localparam logic [4:0] SEL_OR   = 5'h01;
    localparam logic [4:0] SEL_ADD  = 5'h02;
    localparam logic [4:0] SEL_XOR  = 5'h03;
    localparam logic [4:0] SEL_SLL  = 5'h04;
    localparam logic [4:0] SEL_SRL  = 5'h05;
    localparam logic [4:0] SEL_SUB  = 5'h06;
    localparam logic [4:0] SEL_SRA  = 5'h07;
    localparam logic [4:0] SEL_SLT  = 5'h08;
    localparam logic [4:0] SEL_SLTU = 5'h09;
`ifdef ALU_DECODE_ZBB_EN
    localparam logic [4:0] SEL_ROL   = 5'h0D;
    localparam logic [4:0] SEL_ROR   = 5'h0E;
    localparam logic [4:0] SEL_ANDN  = 5'h10;
    localparam logic [4:0] SEL_ORN   = 5'h11;
    localparam logic [4:0] SEL_XNOR  = 5'h12;
    localparam logic [4:0] SEL_CLZ   = 5'h13;
    localparam logic [4:0] SEL_CTZ   = 5'h14;
    localparam logic [4:0] SEL_CPOP  = 5'h15;
    localparam logic [4:0] SEL_MIN   = 5'h16;
    localparam logic [4:0] SEL_MAX   = 5'h17;
    localparam logic [4:0] SEL_SEXTB = 5'h18;
    localparam logic [4:0] SEL_SEXTH = 5'h19;
    localparam logic [4:0] SEL_ZEXTH = 5'h1A;
    localparam logic [4:0] SEL_ORCB  = 5'h1B;
    localparam logic [4:0] SEL_REV8  = 5'h1C;
    localparam logic [4:0] SEL_MINU  = 5'h1D;
    localparam logic [4:0] SEL_MAXU  = 5'h1E;
`endif

    // Operand shape of a legal instruction: register-register, register-
    // immediate, or single-source (unary Zbb ops ignore both rs2 and imm).
    typedef enum logic [1:0] {
        FORM_REG,
        FORM_IMM,
        FORM_UNARY
    } form_e;

    typedef struct packed {
        logic [4:0]  alu_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_imm;
        logic [31:0] imm;
        logic        illegal;
    } entry_t;

    // Only the two-entry arrangement is implemented.
    if (SKID_EN_DEPTH != 2) begin : g_depth_unsupported
        $error("alu_decode_stage: SKID_EN_DEPTH must be 2");
    end

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rs2;
    logic [4:0] w_sel;
    logic       w_legal;
    form_e      w_form;
    entry_t     w_dec;
    logic       w_accept;
    logic       w_deq;

    entry_t     r_main;
    entry_t     r_skid;
    logic       r_main_valid;
    logic       r_skid_valid;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_rs2    = in_instr[24:20];

    // Classify the incoming word: pick the alu_sel code, legality and operand form.
    always_comb begin
        w_sel   = NOP_SEL;
        w_legal = 1'b0;
        w_form  = FORM_REG;
        case (w_opcode)
            OPC_OP: begin
                w_form = FORM_REG;
                if (w_funct7 == 7'b0000000) begin
                    w_legal = 1'b1;
                    case (w_funct3)
                        3'b000:  w_sel = SEL_ADD;
                        3'b001:  w_sel = SEL_SLL;
                        3'b010:  w_sel = SEL_SLT;
                        3'b011:  w_sel = SEL_SLTU;
                        3'b100:  w_sel = SEL_XOR;
                        3'b101:  w_sel = SEL_SRL;
                        3'b110:  w_sel = SEL_OR;
                        default: w_sel = SEL_AND;
                    endcase
                end else if (w_funct7 == 7'b0100000) begin
                    case (w_funct3)
                        3'b000: begin w_sel = SEL_SUB;  w_legal = 1'b1; end
                        3'b101: begin w_sel = SEL_SRA;  w_legal = 1'b1; end
`ifdef ALU_DECODE_ZBB_EN
                        3'b111: begin w_sel = SEL_ANDN; w_legal = 1'b1; end
                        3'b110: begin w_sel = SEL_ORN;  w_legal = 1'b1; end
                        3'b100: begin w_sel = SEL_XNOR; w_legal = 1'b1; end
`endif
                        default: ;
                    endcase
                end
`ifdef ALU_DECODE_ZBB_EN
                else if (w_funct7 == 7'b0000101) begin
                    case (w_funct3)
                        3'b100: begin w_sel = SEL_MIN;  w_legal = 1'b1; end
                        3'b101: begin w_sel = SEL_MINU; w_legal = 1'b1; end
                        3'b110: begin w_sel = SEL_MAX;  w_legal = 1'b1; end
                        3'b111: begin w_sel = SEL_MAXU; w_legal = 1'b1; end
                        default: ;
                    endcase
                end else if (w_funct7 == 7'b0110000) begin
                    case (w_funct3)
                        3'b001: begin w_sel = SEL_ROL; w_legal = 1'b1; end
                        3'b101: begin w_sel = SEL_ROR; w_legal = 1'b1; end
                        default: ;
                    endcase
                end else if (w_funct7 == 7'b0000100 && w_funct3 == 3'b100 && w_rs2 == 5'd0) begin
                    w_sel   = SEL_ZEXTH;
                    w_legal = 1'b1;
                    w_form  = FORM_UNARY;
                end
`endif
            end
            OPC_OPIMM: begin
                w_form = FORM_IMM;
                case (w_funct3)
                    3'b000: begin w_sel = SEL_ADD;  w_legal = 1'b1; end
                    3'b010: begin w_sel = SEL_SLT;  w_legal = 1'b1; end
                    3'b011: begin w_sel = SEL_SLTU; w_legal = 1'b1; end
                    3'b100: begin w_sel = SEL_XOR;  w_legal = 1'b1; end
                    3'b110: begin w_sel = SEL_OR;   w_legal = 1'b1; end
                    3'b111: begin w_sel = SEL_AND;  w_legal = 1'b1; end
                    3'b001: begin
                        if (w_funct7 == 7'b0000000) begin
                            w_sel   = SEL_SLL;
                            w_legal = 1'b1;
                        end
`ifdef ALU_DECODE_ZBB_EN
                        else if (in_instr[31:20] == 12'h600) begin
                            w_sel = SEL_CLZ;   w_legal = 1'b1; w_form = FORM_UNARY;
                        end else if (in_instr[31:20] == 12'h601) begin
                            w_sel = SEL_CTZ;   w_legal = 1'b1; w_form = FORM_UNARY;
                        end else if (in_instr[31:20] == 12'h602) begin
                            w_sel = SEL_CPOP;  w_legal = 1'b1; w_form = FORM_UNARY;
                        end else if (in_instr[31:20] == 12'h604) begin
                            w_sel = SEL_SEXTB; w_legal = 1'b1; w_form = FORM_UNARY;
                        end else if (in_instr[31:20] == 12'h605) begin
                            w_sel = SEL_SEXTH; w_legal = 1'b1; w_form = FORM_UNARY;
                        end
`endif
                    end
                    default: begin
                        if (w_funct7 == 7'b0000000) begin
                            w_sel   = SEL_SRL;
                            w_legal = 1'b1;
                        end else if (w_funct7 == 7'b0100000) begin
                            w_sel   = SEL_SRA;
                            w_legal = 1'b1;
                        end
`ifdef ALU_DECODE_ZBB_EN
                        else if (w_funct7 == 7'b0110000) begin
                            w_sel   = SEL_ROR;
                            w_legal = 1'b1;
                        end else if (in_instr[31:20] == 12'h287) begin
                            w_sel = SEL_ORCB; w_legal = 1'b1; w_form = FORM_UNARY;
                        end else if (in_instr[31:20] == 12'h698) begin
                            w_sel = SEL_REV8; w_legal = 1'b1; w_form = FORM_UNARY;
                        end
`endif
                    end
                endcase
            end
            default: ;
        endcase
    end

    // Assemble the output entry; illegal words collapse to a NOP with zeroed fields.
    always_comb begin
        w_dec         = '0;
        w_dec.alu_sel = NOP_SEL;
        w_dec.illegal = 1'b1;
        if (w_legal) begin
            w_dec.alu_sel = w_sel;
            w_dec.illegal = 1'b0;
            w_dec.rd      = in_instr[11:7];
            w_dec.rs1     = in_instr[19:15];
            case (w_form)
                FORM_REG: w_dec.rs2 = w_rs2;
                FORM_IMM: begin
                    w_dec.use_imm = 1'b1;
                    w_dec.imm     = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                default: ;
            endcase
        end
    end

    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid & in_ready;
    assign w_deq    = r_main_valid & out_ready;

    // Main/skid occupancy: flush wins, then dequeue refills main from skid or input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid   <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_main         <= '0;
            r_main.alu_sel <= NOP_SEL;
            r_skid         <= '0;
            r_skid.alu_sel <= NOP_SEL;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_deq) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main <= w_dec;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid   = r_main_valid;
    assign out_alu_sel = r_main.alu_sel;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_rd      = r_main.rd;
    assign out_use_imm = r_main.use_imm;
    assign out_imm     = r_main.imm;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage: reset, decode table (base and
// ALU_DECODE_ZBB_EN-dependent encodings), backpressure, flush and async reset.

module tb_alu_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_alu_sel;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_use_imm;
    logic [31:0] out_imm;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  sel;
        logic        ill;
        logic        useImm;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    alu_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_sel (out_alu_sel),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_use_imm (out_use_imm),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic vec_t mkOk(input logic [31:0] instr, input logic [4:0] sel,
                                  input logic useImm, input logic [31:0] imm,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2);
        vec_t v;
        v.instr = instr; v.sel = sel; v.ill = 1'b0; v.useImm = useImm;
        v.imm = imm; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        return v;
    endfunction

    function automatic vec_t mkIll(input logic [31:0] instr);
        vec_t v;
        v.instr = instr; v.sel = 5'h0F; v.ill = 1'b1; v.useImm = 1'b0;
        v.imm = 32'h0; v.rd = 5'd0; v.rs1 = 5'd0; v.rs2 = 5'd0;
        return v;
    endfunction

    function automatic vec_t mkZbb(input logic [31:0] instr, input logic [4:0] sel,
                                   input logic useImm, input logic [31:0] imm,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2);
`ifdef ALU_DECODE_ZBB_EN
        return mkOk(instr, sel, useImm, imm, rd, rs1, rs2);
`else
        return mkIll(instr);
`endif
    endfunction

    // Advance one clock and settle just after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #5;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_alu_sel !== 5'h0F) begin errors++; $display("[TB] FAIL reset alu_sel: got %h expected 0f", out_alu_sel); end
        checks++;
        if ({out_rs1, out_rs2, out_rd, out_use_imm, out_imm, out_illegal} !== 49'h0) begin
            errors++;
            $display("[TB] FAIL reset fields: got rs1=%h rs2=%h rd=%h use_imm=%b imm=%h illegal=%b expected all 0",
                     out_rs1, out_rs2, out_rd, out_use_imm, out_imm, out_illegal);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode;
        vec_t q[$];
        // base RV32I OP / OP-IMM
        q.push_back(mkOk(32'h002081B3, 5'h02, 1'b0, 32'h0, 5'd3, 5'd1, 5'd2));
        q.push_back(mkOk(32'hFFF00293, 5'h02, 1'b1, 32'hFFFFFFFF, 5'd5, 5'd0, 5'd0));
        q.push_back(mkOk(encR(7'h20, 5'd5, 5'd4, 3'b000, 5'd6), 5'h06, 1'b0, 32'h0, 5'd6, 5'd4, 5'd5));
        q.push_back(mkOk(encR(7'h20, 5'd7, 5'd6, 3'b101, 5'd8), 5'h07, 1'b0, 32'h0, 5'd8, 5'd6, 5'd7));
        q.push_back(mkOk(encR(7'h00, 5'd1, 5'd2, 3'b011, 5'd9), 5'h09, 1'b0, 32'h0, 5'd9, 5'd2, 5'd1));
        q.push_back(mkOk(encR(7'h00, 5'd3, 5'd3, 3'b001, 5'd1), 5'h04, 1'b0, 32'h0, 5'd1, 5'd3, 5'd3));
        q.push_back(mkOk(encR(7'h00, 5'd4, 5'd5, 3'b010, 5'd2), 5'h08, 1'b0, 32'h0, 5'd2, 5'd5, 5'd4));
        q.push_back(mkOk(encR(7'h00, 5'd6, 5'd7, 3'b100, 5'd10), 5'h03, 1'b0, 32'h0, 5'd10, 5'd7, 5'd6));
        q.push_back(mkOk(encR(7'h00, 5'd8, 5'd9, 3'b101, 5'd11), 5'h05, 1'b0, 32'h0, 5'd11, 5'd9, 5'd8));
        q.push_back(mkOk(encR(7'h00, 5'd10, 5'd11, 3'b110, 5'd12), 5'h01, 1'b0, 32'h0, 5'd12, 5'd11, 5'd10));
        q.push_back(mkOk(encR(7'h00, 5'd12, 5'd13, 3'b111, 5'd14), 5'h00, 1'b0, 32'h0, 5'd14, 5'd13, 5'd12));
        q.push_back(mkOk(encR(7'h00, 5'd31, 5'd30, 3'b000, 5'd29), 5'h02, 1'b0, 32'h0, 5'd29, 5'd30, 5'd31));
        q.push_back(mkOk(encI(12'h403, 5'd1, 3'b101, 5'd4), 5'h07, 1'b1, 32'h00000403, 5'd4, 5'd1, 5'd0));
        q.push_back(mkOk(encI(12'h005, 5'd2, 3'b101, 5'd3), 5'h05, 1'b1, 32'h00000005, 5'd3, 5'd2, 5'd0));
        q.push_back(mkOk(encI(12'h01F, 5'd3, 3'b001, 5'd4), 5'h04, 1'b1, 32'h0000001F, 5'd4, 5'd3, 5'd0));
        q.push_back(mkOk(encI(12'h800, 5'd2, 3'b100, 5'd7), 5'h03, 1'b1, 32'hFFFFF800, 5'd7, 5'd2, 5'd0));
        q.push_back(mkOk(encI(12'h7FF, 5'd8, 3'b011, 5'd9), 5'h09, 1'b1, 32'h000007FF, 5'd9, 5'd8, 5'd0));
        q.push_back(mkOk(encI(12'h0F0, 5'd3, 3'b110, 5'd10), 5'h01, 1'b1, 32'h000000F0, 5'd10, 5'd3, 5'd0));
        q.push_back(mkOk(encI(12'hF0F, 5'd4, 3'b111, 5'd11), 5'h00, 1'b1, 32'hFFFFFF0F, 5'd11, 5'd4, 5'd0));
        q.push_back(mkOk(encI(12'h123, 5'd5, 3'b010, 5'd12), 5'h08, 1'b1, 32'h00000123, 5'd12, 5'd5, 5'd0));
        // always illegal
        q.push_back(mkIll(32'h00000000));
        q.push_back(mkIll(encI(12'h021, 5'd1, 3'b001, 5'd2)));
        q.push_back(mkIll(encI(12'h041, 5'd1, 3'b101, 5'd2)));
        q.push_back(mkIll(encR(7'h20, 5'd1, 5'd2, 3'b001, 5'd3)));
        q.push_back(mkIll(encR(7'h01, 5'd1, 5'd2, 3'b000, 5'd3)));
        q.push_back(mkIll(32'h00002003));
        q.push_back(mkIll(encR(7'h04, 5'd1, 5'd5, 3'b100, 5'd6)));
        q.push_back(mkIll(encI(12'h603, 5'd1, 3'b001, 5'd2)));
        q.push_back(mkIll(encR(7'h05, 5'd1, 5'd2, 3'b000, 5'd3)));
        // Zbb: legal only when ALU_DECODE_ZBB_EN is defined
        q.push_back(mkZbb(32'h60011093, 5'h13, 1'b0, 32'h0, 5'd1, 5'd2, 5'd0));
        q.push_back(mkZbb(encI(12'h601, 5'd3, 3'b001, 5'd4), 5'h14, 1'b0, 32'h0, 5'd4, 5'd3, 5'd0));
        q.push_back(mkZbb(encI(12'h602, 5'd3, 3'b001, 5'd4), 5'h15, 1'b0, 32'h0, 5'd4, 5'd3, 5'd0));
        q.push_back(mkZbb(encI(12'h604, 5'd3, 3'b001, 5'd4), 5'h18, 1'b0, 32'h0, 5'd4, 5'd3, 5'd0));
        q.push_back(mkZbb(encI(12'h605, 5'd3, 3'b001, 5'd4), 5'h19, 1'b0, 32'h0, 5'd4, 5'd3, 5'd0));
        q.push_back(mkZbb(encI(12'h287, 5'd6, 3'b101, 5'd7), 5'h1B, 1'b0, 32'h0, 5'd7, 5'd6, 5'd0));
        q.push_back(mkZbb(encI(12'h698, 5'd6, 3'b101, 5'd7), 5'h1C, 1'b0, 32'h0, 5'd7, 5'd6, 5'd0));
        q.push_back(mkZbb(encI(12'h603, 5'd1, 3'b101, 5'd2), 5'h0E, 1'b1, 32'h00000603, 5'd2, 5'd1, 5'd0));
        q.push_back(mkZbb(encR(7'h20, 5'd2, 5'd1, 3'b111, 5'd3), 5'h10, 1'b0, 32'h0, 5'd3, 5'd1, 5'd2));
        q.push_back(mkZbb(encR(7'h20, 5'd2, 5'd1, 3'b110, 5'd3), 5'h11, 1'b0, 32'h0, 5'd3, 5'd1, 5'd2));
        q.push_back(mkZbb(encR(7'h20, 5'd2, 5'd1, 3'b100, 5'd3), 5'h12, 1'b0, 32'h0, 5'd3, 5'd1, 5'd2));
        q.push_back(mkZbb(encR(7'h05, 5'd4, 5'd5, 3'b100, 5'd6), 5'h16, 1'b0, 32'h0, 5'd6, 5'd5, 5'd4));
        q.push_back(mkZbb(encR(7'h05, 5'd4, 5'd5, 3'b101, 5'd6), 5'h1D, 1'b0, 32'h0, 5'd6, 5'd5, 5'd4));
        q.push_back(mkZbb(encR(7'h05, 5'd4, 5'd5, 3'b110, 5'd6), 5'h17, 1'b0, 32'h0, 5'd6, 5'd5, 5'd4));
        q.push_back(mkZbb(encR(7'h05, 5'd4, 5'd5, 3'b111, 5'd6), 5'h1E, 1'b0, 32'h0, 5'd6, 5'd5, 5'd4));
        q.push_back(mkZbb(encR(7'h30, 5'd8, 5'd9, 3'b001, 5'd10), 5'h0D, 1'b0, 32'h0, 5'd10, 5'd9, 5'd8));
        q.push_back(mkZbb(encR(7'h30, 5'd8, 5'd9, 3'b101, 5'd10), 5'h0E, 1'b0, 32'h0, 5'd10, 5'd9, 5'd8));
        q.push_back(mkZbb(encR(7'h04, 5'd0, 5'd5, 3'b100, 5'd6), 5'h1A, 1'b0, 32'h0, 5'd6, 5'd5, 5'd0));

        // Stream every vector back-to-back with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            in_valid = 1'b1;
            in_instr = q[i].instr;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL decode[%0d] in_ready: got %b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL decode[%0d] out_valid: got %b expected 1", i, out_valid);
            end
            checks++;
            if ({out_alu_sel, out_illegal, out_use_imm, out_imm, out_rd} !==
                {q[i].sel, q[i].ill, q[i].useImm, q[i].imm, q[i].rd}) begin
                errors++;
                $display("[TB] FAIL decode[%0d] instr=%h: got sel=%h ill=%b use_imm=%b imm=%h rd=%0d expected sel=%h ill=%b use_imm=%b imm=%h rd=%0d",
                         i, q[i].instr, out_alu_sel, out_illegal, out_use_imm, out_imm, out_rd,
                         q[i].sel, q[i].ill, q[i].useImm, q[i].imm, q[i].rd);
            end
            if (!q[i].ill) begin
                checks++;
                if ({out_rs1, out_rs2} !== {q[i].rs1, q[i].rs2}) begin
                    errors++;
                    $display("[TB] FAIL decode[%0d] regs: got rs1=%0d rs2=%0d expected rs1=%0d rs2=%0d",
                             i, out_rs1, out_rs2, q[i].rs1, q[i].rs2);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL decode drain out_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] instrA;
        logic [31:0] instrB;
        logic [31:0] instrC;
        instrA = encR(7'h00, 5'd1, 5'd2, 3'b000, 5'd10);
        instrB = encR(7'h20, 5'd3, 5'd4, 3'b000, 5'd11);
        instrC = encI(12'h010, 5'd5, 3'b000, 5'd12);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = instrA;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp in_ready A: got %b expected 1", in_ready); end
        tick();
        in_instr = instrB;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp in_ready B: got %b expected 1", in_ready); end
        tick();
        in_instr = instrC;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp in_ready C: got %b expected 0", in_ready); end
        tick();
        checks++;
        if ({out_valid, out_rd, out_alu_sel} !== {1'b1, 5'd10, 5'h02}) begin
            errors++;
            $display("[TB] FAIL bp head A: got valid=%b rd=%0d sel=%h expected valid=1 rd=10 sel=02", out_valid, out_rd, out_alu_sel);
        end
        tick();
        checks++;
        if ({out_valid, out_rd, out_alu_sel, in_ready} !== {1'b1, 5'd10, 5'h02, 1'b0}) begin
            errors++;
            $display("[TB] FAIL bp hold A: got valid=%b rd=%0d sel=%h in_ready=%b expected 1 10 02 0",
                     out_valid, out_rd, out_alu_sel, in_ready);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_rd, out_alu_sel, in_ready} !== {1'b1, 5'd11, 5'h06, 1'b1}) begin
            errors++;
            $display("[TB] FAIL bp second B: got valid=%b rd=%0d sel=%h in_ready=%b expected 1 11 06 1",
                     out_valid, out_rd, out_alu_sel, in_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_rd, out_alu_sel, out_use_imm, out_imm} !== {1'b1, 5'd12, 5'h02, 1'b1, 32'h10}) begin
            errors++;
            $display("[TB] FAIL bp third C: got valid=%b rd=%0d sel=%h use_imm=%b imm=%h expected 1 12 02 1 00000010",
                     out_valid, out_rd, out_alu_sel, out_use_imm, out_imm);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp drained out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush;
        // both entries full, input valid during flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = encR(7'h00, 5'd1, 5'd1, 3'b000, 5'd20);
        tick();
        in_instr = encR(7'h00, 5'd1, 5'd1, 3'b000, 5'd21);
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush full in_ready: got %b expected 0", in_ready); end
        in_instr = encR(7'h00, 5'd1, 5'd1, 3'b000, 5'd22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL flush full result: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush full after: got out_valid=%b expected 0", out_valid); end
        // main full, skid empty: the input is acceptable but must be dropped
        in_valid = 1'b1;
        in_instr = encR(7'h00, 5'd1, 5'd1, 3'b000, 5'd23);
        tick();
        in_instr = encR(7'h00, 5'd1, 5'd1, 3'b000, 5'd24);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL flush half result: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush half dropped: got out_valid=%b expected 0", out_valid); end
        // traffic resumes normally
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = encR(7'h00, 5'd2, 5'd3, 3'b100, 5'd25);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_rd, out_alu_sel} !== {1'b1, 5'd25, 5'h03}) begin
            errors++;
            $display("[TB] FAIL flush resume: got valid=%b rd=%0d sel=%h expected 1 25 03", out_valid, out_rd, out_alu_sel);
        end
        tick();
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = encR(7'h00, 5'd1, 5'd2, 3'b110, 5'd26);
        tick();
        in_instr = encR(7'h00, 5'd1, 5'd2, 3'b111, 5'd27);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_alu_sel, in_ready} !== {1'b1, 5'h01, 1'b0}) begin
            errors++;
            $display("[TB] FAIL areset pre: got valid=%b sel=%h in_ready=%b expected 1 01 0", out_valid, out_alu_sel, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_alu_sel, out_rd, in_ready} !== {1'b0, 5'h0F, 5'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL areset immediate: got valid=%b sel=%h rd=%0d in_ready=%b expected 0 0f 0 1",
                     out_valid, out_alu_sel, out_rd, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset after: got out_valid=%b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
